// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT framing defaults and the bit-reversal index helper.
package fft_pkg;
  localparam int FFT_N = 8;
  localparam int FFT_NUM_SIZE = 32;
  function automatic int unsigned bit_reverse(input int unsigned k, input int unsigned bits);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < bits; i++) r = (r << 1) | ((k >> i) & 1);
    return r;
  endfunction
endpackage

// File: rtl/fft_frame_bank.sv
// fft_frame_bank: one N x NUM_SIZE sample bank with slot-addressed writes,
// a flattened read port and asynchronous clear.
module fft_frame_bank #(
  parameter int N = 8,
  parameter int NUM_SIZE = 32,
  localparam int AW = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_addr,
  input  logic [NUM_SIZE-1:0]   i_data,
  output logic [N*NUM_SIZE-1:0] o_data
);
  logic [N-1:0][NUM_SIZE-1:0] r_mem;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_mem <= '0;
    else if (i_we) r_mem[i_addr] <= i_data;
  assign o_data = r_mem;
endmodule

// File: rtl/fft_input_framer.sv
// fft_input_framer: ping-pong framer collecting N samples per frame for an FFT.
// Define FFT_INPUT_FRAMER_BITREV_EN to store frames in bit-reversed slot order.
module fft_input_framer import fft_pkg::*; #(
  parameter int N = FFT_N,
  parameter int NUM_SIZE = FFT_NUM_SIZE,
  localparam int AW = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_SIZE-1:0]   in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*NUM_SIZE-1:0] out_data,
  output logic                  frame_err
);
  logic [1:0]           r_full;
  logic                 r_wr_bank;
  logic                 r_rd_bank;
  logic [AW-1:0]        r_wr_cnt;
  logic                 r_frame_err;
  logic [1:0]           w_full_nxt;
  logic                 w_acc, w_end, w_short, w_done, w_rel, w_we;
  logic [AW-1:0]        w_addr;
  logic [N*NUM_SIZE-1:0] w_d0, w_d1;
  assign in_ready  = !r_full[r_wr_bank];
  assign out_valid = r_full[r_rd_bank];
  assign out_data  = r_rd_bank ? w_d1 : w_d0;
  assign frame_err = r_frame_err;
  assign w_acc   = in_valid && in_ready;
  assign w_end   = r_wr_cnt == AW'(N - 1);
  assign w_done  = w_acc && w_end;
  // A premature in_last drops its own sample and restarts the frame.
  assign w_short = w_acc && in_last && !w_end;
  assign w_we    = w_acc && !w_short;
  assign w_rel   = out_valid && out_ready;
`ifdef FFT_INPUT_FRAMER_BITREV_EN
  assign w_addr = AW'(bit_reverse(32'(r_wr_cnt), AW));
`else
  assign w_addr = r_wr_cnt;
`endif
  always_comb begin
    w_full_nxt = r_full;
    if (w_done) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_rel) w_full_nxt[r_rd_bank] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_full      <= '0;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_wr_cnt    <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_full      <= w_full_nxt;
      r_wr_bank   <= r_wr_bank ^ w_done;
      r_rd_bank   <= r_rd_bank ^ w_rel;
      r_wr_cnt    <= (w_done || w_short) ? '0 : w_acc ? r_wr_cnt + 1'b1 : r_wr_cnt;
      r_frame_err <= w_short;
    end
  fft_frame_bank #(.N(N), .NUM_SIZE(NUM_SIZE)) u_bank0 (
    .clk(clk), .rst_n(rst_n), .i_we(w_we && !r_wr_bank), .i_addr(w_addr),
    .i_data(in_data), .o_data(w_d0)
  );
  fft_frame_bank #(.N(N), .NUM_SIZE(NUM_SIZE)) u_bank1 (
    .clk(clk), .rst_n(rst_n), .i_we(w_we && r_wr_bank), .i_addr(w_addr),
    .i_data(in_data), .o_data(w_d1)
  );
endmodule

// File: tb/tb_fft_input_framer.sv
// tb_fft_input_framer: directed checks of framing, back-pressure, short frames,
// overlap of completion and release, reset mid-frame and output stability.
module tb_fft_input_framer;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [255:0] out_data;
  logic         frame_err;
  int           n_chk = 0;
  int           n_err = 0;
  fft_input_framer #(.N(8), .NUM_SIZE(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  function automatic int exp_slot(input int k);
    logic [2:0] kk;
    kk = k[2:0];
`ifdef FFT_INPUT_FRAMER_BITREV_EN
    return int'({kk[0], kk[1], kk[2]});
`else
    return int'(kk);
`endif
  endfunction
  function automatic logic [255:0] frame(input int base);
    logic [255:0] f;
    f = '0;
    for (int k = 0; k < 8; k++) f[exp_slot(k)*32 +: 32] = 32'(base + k);
    return f;
  endfunction
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int d, input logic last);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_data  = 32'(d);
    in_last  = last;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    chk("send_in_ready", 256'(in_ready), 256'(1));
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_data", out_data, 256'(0));
    chk("rst_frame_err", 256'(frame_err), 256'(0));
    @(negedge clk) rst_n = 1'b1;
    tick();
    // streaming with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) send(i, 1'b0);
    chk("stream_no_early_valid", 256'(out_valid), 256'(0));
    send(7, 1'b0);
    chk("stream_valid", 256'(out_valid), 256'(1));
    chk("stream_data", out_data, frame(0));
    tick();
    chk("stream_released", 256'(out_valid), 256'(0));
    // two frames with back-pressure
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(i, 1'b0);
    chk("bp_in_ready_low", 256'(in_ready), 256'(0));
    chk("bp_valid", 256'(out_valid), 256'(1));
    for (int c = 0; c < 10; c++) begin
      chk("hold_data", out_data, frame(0));
      chk("hold_valid", 256'(out_valid), 256'(1));
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_in_ready_rise", 256'(in_ready), 256'(1));
    chk("bp_second_valid", 256'(out_valid), 256'(1));
    chk("bp_second_data", out_data, frame(8));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_drained", 256'(out_valid), 256'(0));
    // short frame
    send(0, 1'b0);
    send(1, 1'b0);
    send(2, 1'b1);
    chk("short_err_pulse", 256'(frame_err), 256'(1));
    chk("short_no_valid", 256'(out_valid), 256'(0));
    tick();
    chk("short_err_clear", 256'(frame_err), 256'(0));
    for (int i = 20; i < 28; i++) send(i, 1'b0);
    chk("short_next_valid", 256'(out_valid), 256'(1));
    chk("short_next_data", out_data, frame(20));
    chk("short_next_err", 256'(frame_err), 256'(0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("short_drained", 256'(out_valid), 256'(0));
    // completion and release in the same cycle
    for (int i = 30; i < 38; i++) send(i, 1'b0);
    for (int i = 40; i < 47; i++) send(i, 1'b0);
    chk("ovl_first_data", out_data, frame(30));
    out_ready = 1'b1;
    send(47, 1'b0);
    out_ready = 1'b0;
    chk("ovl_valid", 256'(out_valid), 256'(1));
    chk("ovl_data", out_data, frame(40));
    chk("ovl_in_ready", 256'(in_ready), 256'(1));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ovl_drained", 256'(out_valid), 256'(0));
    // reset with one full bank pending and a partial frame
    for (int i = 50; i < 58; i++) send(i, 1'b0);
    for (int i = 60; i < 65; i++) send(i, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 256'(out_valid), 256'(0));
    chk("arst_out_data", out_data, 256'(0));
    chk("arst_in_ready", 256'(in_ready), 256'(1));
    @(negedge clk) rst_n = 1'b1;
    tick();
    for (int i = 70; i < 78; i++) send(i, 1'b0);
    chk("arst_clean_valid", 256'(out_valid), 256'(1));
    chk("arst_clean_data", out_data, frame(70));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
